branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 37 +++
 rtl/branch_predictor_sat_cnt.sv | 22 ++
 rtl/branch_predictor.sv | 102 ++++++++++
 tb/tb_branch_predictor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared ISA macros (opcodes, word types) and decode helpers for the branch predictor
`ifndef BP_UTILS_DEFINED
`define BP_UTILS_DEFINED
`define ADDR_TP     logic [31:0]
`define WORD_TP     logic [31:0]
`define OPC_BR      7'b1100011
`define OPC_JAL     7'b1101111
`define NEXT_PC_INC 32'd4
`define TRUE        1'b1
`define FALSE       1'b0
`endif

package branch_predictor_pkg;

  typedef enum logic [1:0] {
    OP_BRANCH,
    OP_JUMP,
    OP_OTHER
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] opcode);
    case (opcode)
      `OPC_BR:  return OP_BRANCH;
      `OPC_JAL: return OP_JUMP;
      default:  return OP_OTHER;
    endcase
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/branch_predictor_sat_cnt.sv
// rtl/branch_predictor_sat_cnt.sv - saturating up/down counter next-state logic (module sat_cnt)
module sat_cnt #(
  parameter int W = 2
) (
  input  logic [W-1:0] cur,
  input  logic         inc,
  output logic [W-1:0] nxt
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_MIN = '0;

  always_comb begin
    nxt = cur;
    if (inc && (cur != CNT_MAX)) begin
      nxt = cur + W'(1);
    end else if (!inc && (cur != CNT_MIN)) begin
      nxt = cur - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal/gshare BHT branch predictor; define GSHARE_EN for global-history XOR indexing
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int CNT_W = 2,
  parameter int IDX_W = 8,
  parameter int GHR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pd_ena,
  input  `ADDR_TP          pd_pc,
  input  `WORD_TP          pd_inst,
  output logic             pd_taken_stat,
  output `WORD_TP          pd_off,
  output logic [IDX_W-1:0] pd_idx,
  input  logic             fb_ena,
  input  logic             fb_taken_stat,
  input  logic [IDX_W-1:0] fb_idx,
  input  logic             fb_miss,
  output logic [31:0]      stat_br_cnt,
  output logic [31:0]      stat_miss_cnt
);

  localparam int BHT_N = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0] bht_q [BHT_N];
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [31:0]      br_cnt_q, br_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] fb_cnt_nxt;
  logic [IDX_W-1:0] pc_idx;
  logic             pc_unused;

  sat_cnt #(.W(CNT_W)) u_sat_cnt (
    .cur (bht_q[fb_idx]),
    .inc (fb_taken_stat),
    .nxt (fb_cnt_nxt)
  );

  assign pc_idx    = pd_pc[IDX_W+1:2];
  assign pc_unused = ^{pd_pc[31:IDX_W+2], pd_pc[1:0]};

`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr_ext;
  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr_q;
  end
  assign pd_idx = pc_idx ^ ghr_ext;
`else
  // History still shifts in bimodal builds so switching modes keeps identical update timing.
  assign pd_idx = pc_idx;
`endif

  // Prediction reads pre-update state; same-cycle feedback is deliberately not bypassed.
  always_comb begin
    pd_taken_stat = `FALSE;
    pd_off        = `NEXT_PC_INC;
    case (classify(pd_inst[6:0]))
      OP_BRANCH: begin
        pd_taken_stat = bht_q[pd_idx][CNT_W-1];
        pd_off        = imm_b(pd_inst);
      end
      OP_JUMP: begin
        pd_taken_stat = `TRUE;
        pd_off        = imm_j(pd_inst);
      end
      default: ;
    endcase
    if (!pd_ena || rst) begin
      pd_taken_stat = `FALSE;
    end
  end

  always_comb begin
    ghr_d      = (ghr_q << 1) | GHR_W'(fb_taken_stat);
    br_cnt_d   = br_cnt_q + 32'd1;
    miss_cnt_d = fb_miss ? (miss_cnt_q + 32'd1) : miss_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= CNT_WEAK_NT;
      end
      ghr_q      <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else if (fb_ena) begin
      bht_q[fb_idx] <= fb_cnt_nxt;
      ghr_q         <= ghr_d;
      br_cnt_q      <= br_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  assign stat_br_cnt   = br_cnt_q;
  assign stat_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor against a behavioural model
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pd_ena;
  logic [31:0] pd_pc;
  logic [31:0] pd_inst;
  logic        pd_taken_stat;
  logic [31:0] pd_off;
  logic [7:0]  pd_idx;
  logic        fb_ena;
  logic        fb_taken_stat;
  logic [7:0]  fb_idx;
  logic        fb_miss;
  logic [31:0] stat_br_cnt;
  logic [31:0] stat_miss_cnt;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .pd_ena        (pd_ena),
    .pd_pc         (pd_pc),
    .pd_inst       (pd_inst),
    .pd_taken_stat (pd_taken_stat),
    .pd_off        (pd_off),
    .pd_idx        (pd_idx),
    .fb_ena        (fb_ena),
    .fb_taken_stat (fb_taken_stat),
    .fb_idx        (fb_idx),
    .fb_miss       (fb_miss),
    .stat_br_cnt   (stat_br_cnt),
    .stat_miss_cnt (stat_miss_cnt)
  );

  typedef struct {
    int          seq;
    logic        taken;
    logic [31:0] off;
    logic [7:0]  idx;
    logic [31:0] br;
    logic [31:0] miss;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   seq_n  = 0;

  // Reference model: counters as plain integers 0..3, history as an integer.
  int          m_bht[256];
  int          m_ghr;
  logic [31:0] m_br;
  logic [31:0] m_miss;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) m_bht[i] = 1;
    m_ghr  = 0;
    m_br   = 0;
    m_miss = 0;
  endfunction

  function automatic logic [31:0] enc_b(input int off);
    logic [31:0] o;
    o = off;
    return {o[12], o[10:5], 5'd3, 5'd2, 3'b001, o[4:1], o[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int off);
    logic [31:0] o;
    o = off;
    return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_other();
    logic [31:0] r;
    r = $urandom;
    while (r[6:0] == 7'h63 || r[6:0] == 7'h6F) r = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] pc_for(input logic [7:0] i);
    logic [31:0] r;
    r = $urandom;
    return {r[31:10], i, r[1:0]};
  endfunction

  // kind: 0 = branch, 1 = jal, 2 = other
  task automatic step(input bit r, input bit ena, input logic [31:0] pc, input int kind,
                      input int off, input bit f_en, input bit f_t, input logic [7:0] f_idx,
                      input bit f_miss);
    exp_t e;
    int   idx;
    @(posedge clk);
    #1;
    rst           = r;
    pd_ena        = ena;
    pd_pc         = pc;
    fb_ena        = f_en;
    fb_taken_stat = f_t;
    fb_idx        = f_idx;
    fb_miss       = f_miss;
    case (kind)
      0:       pd_inst = enc_b(off);
      1:       pd_inst = enc_j(off);
      default: pd_inst = enc_other();
    endcase
    idx = (pc >> 2) & 255;
`ifdef GSHARE_EN
    idx = idx ^ m_ghr;
`endif
    e.seq   = seq_n++;
    e.idx   = idx[7:0];
    e.off   = (kind == 2) ? 32'd4 : off;
    e.taken = (kind == 1) || (kind == 0 && m_bht[idx] >= 2);
    if (!ena || r) e.taken = 1'b0;
    e.br    = m_br;
    e.miss  = m_miss;
    exp_q.push_back(e);
    if (r) begin
      model_reset();
    end else if (f_en) begin
      if (f_t) m_bht[f_idx] = (m_bht[f_idx] == 3) ? 3 : m_bht[f_idx] + 1;
      else     m_bht[f_idx] = (m_bht[f_idx] == 0) ? 0 : m_bht[f_idx] - 1;
      m_ghr = ((m_ghr << 1) | int'(f_t)) & 255;
      m_br  = m_br + 1;
      if (f_miss) m_miss = m_miss + 1;
    end
  endtask

  task automatic chk(input string name, input int seq, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s seq=%0d got=%h want=%h", name, seq, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pd_taken_stat", e.seq, {31'd0, pd_taken_stat}, {31'd0, e.taken});
      chk("pd_off",        e.seq, pd_off, e.off);
      chk("pd_idx",        e.seq, {24'd0, pd_idx}, {24'd0, e.idx});
      chk("stat_br_cnt",   e.seq, stat_br_cnt, e.br);
      chk("stat_miss_cnt", e.seq, stat_miss_cnt, e.miss);
    end
  end

  initial begin
    rst = 1'b1; pd_ena = 1'b0; pd_pc = '0; pd_inst = '0;
    fb_ena = 1'b0; fb_taken_stat = 1'b0; fb_idx = '0; fb_miss = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // reset state, then a branch with offset -8
    step(0, 1, pc_for(8'd0), 0, -8, 0, 0, 8'd0, 0);
    // three taken feedbacks to idx 5 with same-cycle predictions, then a plain prediction
    for (int i = 0; i < 3; i++) step(0, 1, pc_for(8'd5), 0, 64, 1, 1, 8'd5, 0);
    step(0, 1, pc_for(8'd5), 0, -4096, 0, 0, 8'd0, 0);
    // same-cycle feedback and prediction on idx 5 from weakly-not-taken
    step(1, 0, pc_for(8'd0), 2, 0, 0, 0, 8'd0, 0);
    step(0, 1, pc_for(8'd5), 0, 4094, 1, 1, 8'd5, 1);
    step(0, 1, pc_for(8'd5), 0, 12, 0, 0, 8'd0, 0);
    // jal with pd_ena low, feedback still lands
    step(0, 0, pc_for(8'd9), 1, 2048, 1, 1, 8'd9, 0);
    step(0, 1, pc_for(8'd9), 0, -2, 0, 0, 8'd0, 0);
    step(0, 1, pc_for(8'd9), 1, -1048576, 0, 0, 8'd0, 0);
    // reset wins over simultaneous feedback; first post-reset branch is not-taken
    step(0, 0, pc_for(8'd9), 2, 0, 1, 1, 8'd9, 1);
    step(1, 1, pc_for(8'd9), 1, 100, 1, 1, 8'd9, 1);
    step(0, 1, pc_for(8'd9), 0, 16, 0, 0, 8'd0, 0);
    // fb_miss without fb_ena is ignored
    step(0, 1, pc_for(8'd1), 2, 0, 0, 1, 8'd1, 1);
    step(0, 1, pc_for(8'd1), 2, 0, 0, 0, 8'd0, 0);
    // history shift then pc 0x10 (idx 7 when history indexing is enabled)
    step(1, 0, pc_for(8'd0), 2, 0, 0, 0, 8'd0, 0);
    step(0, 0, pc_for(8'd0), 2, 0, 1, 1, 8'h20, 0);
    step(0, 0, pc_for(8'd0), 2, 0, 1, 1, 8'h20, 0);
    step(0, 1, 32'h0000_0010, 0, 8, 0, 0, 8'd0, 0);

    for (int n = 0; n < 800; n++) begin
      int kind, off, t;
      bit r;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        t = $urandom_range(0, 4095);
        off = (t - 2048) * 2;
      end else if (kind == 1) begin
        t = $urandom_range(0, 1048575);
        off = (t - 524288) * 2;
      end else begin
        off = 0;
      end
      r = ($urandom_range(0, 149) == 0);
      step(r, 1'($urandom), pc_for(8'($urandom_range(0, 7))), kind, off,
           1'($urandom), 1'($urandom), 8'($urandom_range(0, 7)), 1'($urandom));
    end

    @(posedge clk);
    #1;
    pd_ena = 1'b0; fb_ena = 1'b0; rst = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
